timer_irq_ctrl: RTL and testbench

Interrupt controller that schedules the IRQ lines of up to eight timer and peripheral sources onto the CPU's single hardware-interrupt input. It sits on the peripheral bus beside the timers, exposes a four-word register window with the same bus signalling as the timers, and picks the highest-priority source. It runs a request/acknowledge/end-of-interrupt handshake with the CPU exception logic so that only one interrupt is in service at a time.

---
 rtl/timer_irq_ctrl.sv | 148 ++++++++++++++
 tb/tb_timer_irq_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
// Priority interrupt controller: merges up to eight timer/peripheral IRQ lines onto one CPU
// interrupt with a request / acknowledge / end-of-interrupt handshake and a 4-word register window.
module timer_irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [7:2]       ADD_I,
    input  logic             WE_I,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    input  logic [N_SRC-1:0] HWINT_I,
    output logic             IRQ_O,
    output logic [2:0]       VEC_O,
    input  logic             ACK_I
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        SERV = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] hw_q;
    logic [N_SRC-1:0] en_q;
    logic             ge_q;
    logic [N_SRC-1:0] trig_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [2:0]       isr_vec_q, isr_vec_d;
    logic             irq_q, irq_d;
    logic [2:0]       vec_q, vec_d;

    logic [N_SRC-1:0] edge_det, pend, active, w1c_clr, ack_clr;
    logic [2:0]       win;
    logic             wr_mask, wr_pend, wr_trig, wr_eoi;
    logic             unused_bits;

    assign unused_bits = ^{ADD_I[7:4], DAT_I};

    assign wr_mask = WE_I && (ADD_I[3:2] == 2'b00);
    assign wr_pend = WE_I && (ADD_I[3:2] == 2'b01);
    assign wr_trig = WE_I && (ADD_I[3:2] == 2'b10);
    assign wr_eoi  = WE_I && (ADD_I[3:2] == 2'b11);

    // pend_q only holds edge-triggered bits; level bits follow the registered line directly
    assign edge_det = HWINT_I & ~hw_q;
    assign pend     = (pend_q & trig_q) | (hw_q & ~trig_q);
    assign active   = ge_q ? (pend & en_q) : '0;
    assign w1c_clr  = wr_pend ? DAT_I[N_SRC-1:0] : '0;

    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) win = 3'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_d     = 1'b0;
        vec_d     = '0;
        isr_vec_d = isr_vec_q;
        ack_clr   = '0;
        case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = REQ;
                    irq_d   = 1'b1;
                    vec_d   = win;
                end
            end
            REQ: begin
                if (ACK_I) begin
                    state_d   = SERV;
                    isr_vec_d = vec_q;
                    for (int i = 0; i < N_SRC; i++) begin
                        if (vec_q == 3'(i)) ack_clr[i] = 1'b1;
                    end
                end else if (!(|active)) begin
                    state_d = IDLE;
                end else begin
                    irq_d = 1'b1;
                    vec_d = win;
                end
            end
            SERV: begin
                if (wr_eoi) begin
                    state_d   = IDLE;
                    isr_vec_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // a new edge wins over a W1C or ACK clear landing in the same cycle
    assign pend_d = ((pend_q & ~(w1c_clr | ack_clr)) | edge_det) & trig_q;

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q   <= IDLE;
            hw_q      <= '0;
            en_q      <= '0;
            ge_q      <= 1'b0;
            trig_q    <= '0;
            pend_q    <= '0;
            isr_vec_q <= '0;
            irq_q     <= 1'b0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            hw_q      <= HWINT_I;
            pend_q    <= pend_d;
            isr_vec_q <= isr_vec_d;
            irq_q     <= irq_d;
            vec_q     <= vec_d;
            if (wr_mask) begin
                en_q <= DAT_I[N_SRC-1:0];
                ge_q <= DAT_I[31];
            end
            if (wr_trig) trig_q <= DAT_I[N_SRC-1:0];
        end
    end

    always_comb begin
        DAT_O = '0;
        if (RST_I) begin
            case (ADD_I[3:2])
                2'b00: begin
                    DAT_O[31]        = ge_q;
                    DAT_O[N_SRC-1:0] = en_q;
                end
                2'b01: DAT_O[N_SRC-1:0] = pend;
                2'b10: DAT_O[N_SRC-1:0] = trig_q;
                default: begin
                    DAT_O[31]  = (state_q == SERV);
                    DAT_O[9:8] = state_q;
                    DAT_O[2:0] = isr_vec_q;
                end
            endcase
        end
    end

    assign IRQ_O = irq_q;
    assign VEC_O = vec_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Scoreboard bench for timer_irq_ctrl: directed scenarios plus random traffic, all predicted
// by a per-source behavioural model and checked by an independent negedge monitor.
module tb_timer_irq_ctrl;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:2]    add;
    logic          we;
    logic [31:0]   dat_i;
    logic [31:0]   dat_o;
    logic [N-1:0]  hwint;
    logic          irq;
    logic [2:0]    vec;
    logic          ack;

    always #10 clk = ~clk;

    timer_irq_ctrl #(.N_SRC(N)) dut (
        .CLK_I   (clk),
        .RST_I   (rst_n),
        .ADD_I   (add),
        .WE_I    (we),
        .DAT_I   (dat_i),
        .DAT_O   (dat_o),
        .HWINT_I (hwint),
        .IRQ_O   (irq),
        .VEC_O   (vec),
        .ACK_I   (ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        irq;
        logic [2:0]  vec;
        logic [31:0] dat;
    } exp_t;
    exp_t exp_q[$];

    // behavioural model: 0 = idle, 1 = requesting, 2 = in service
    int           m_state;
    bit           m_ge;
    bit [N-1:0]   m_en, m_trig, m_edge_pend, m_hw;
    bit           m_irq;
    bit [2:0]     m_vec, m_isr;
    logic [N-1:0] hw_cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit [N-1:0] m_pend();
        bit [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_trig[i] ? m_edge_pend[i] : m_hw[i];
        return p;
    endfunction

    function automatic int m_winner();
        int best = -1;
        bit [N-1:0] p = m_pend();
        if (!m_ge) return -1;
        for (int i = N - 1; i >= 0; i--) if (p[i] && m_en[i]) best = i;
        return best;
    endfunction

    function automatic bit [31:0] m_read(input bit [1:0] a);
        bit [31:0] r = '0;
        case (a)
            2'd0: begin r[31] = m_ge; r[N-1:0] = m_en; end
            2'd1: r[N-1:0] = m_pend();
            2'd2: r[N-1:0] = m_trig;
            default: begin
                r[31]  = (m_state == 2);
                r[9:8] = 2'(m_state);
                r[2:0] = m_isr;
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ge = 0; m_en = '0; m_trig = '0; m_edge_pend = '0;
        m_hw = '0; m_irq = 0; m_vec = '0; m_isr = '0;
    endtask

    task automatic model_step(input bit r, input bit [N-1:0] h, input bit [1:0] a,
                              input bit w, input bit [31:0] d, input bit k);
        int         win;
        bit [N-1:0] ep;
        if (!r) begin
            model_reset();
            return;
        end
        win = m_winner();
        for (int i = 0; i < N; i++) begin
            if (!m_trig[i])                                      ep[i] = 1'b0;
            else if (h[i] && !m_hw[i])                           ep[i] = 1'b1;
            else if ((w && a == 2'd1 && d[i]) ||
                     (m_state == 1 && k && int'(m_vec) == i))   ep[i] = 1'b0;
            else                                                 ep[i] = m_edge_pend[i];
        end
        case (m_state)
            0: if (win >= 0) begin m_state = 1; m_irq = 1; m_vec = 3'(win); end
               else begin m_irq = 0; m_vec = 0; end
            1: if (k) begin m_state = 2; m_isr = m_vec; m_irq = 0; m_vec = 0; end
               else if (win < 0) begin m_state = 0; m_irq = 0; m_vec = 0; end
               else begin m_irq = 1; m_vec = 3'(win); end
            default: begin
                m_irq = 0; m_vec = 0;
                if (w && a == 2'd3) begin m_state = 0; m_isr = 0; end
            end
        endcase
        m_edge_pend = ep;
        if (w && a == 2'd0) begin m_ge = d[31]; m_en = d[N-1:0]; end
        if (w && a == 2'd2) m_trig = d[N-1:0];
        m_hw = h;
    endtask

    // drive one clock worth of inputs, queue the expected outputs for this cycle
    task automatic cycle(input bit [N-1:0] h, input bit [1:0] a, input bit w,
                         input bit [31:0] d, input bit k, input bit r);
        exp_t e;
        rst_n = r; hwint = h; add = {4'($urandom_range(0, 15)), a};
        we = w; dat_i = d; ack = k;
        e.irq = m_irq; e.vec = m_vec; e.dat = r ? m_read(a) : 32'h0;
        exp_q.push_back(e);
        @(posedge clk);
        model_step(r, h, a, w, d, k);
        #1;
    endtask

    task automatic wr(input bit [1:0] a, input bit [31:0] d);
        cycle(hw_cur, a, 1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic step(input int n);
        repeat (n) cycle(hw_cur, 2'd1, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic ackc();
        cycle(hw_cur, 2'd3, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic peek(input bit [1:0] a, input string name, input logic [31:0] exp);
        add = {4'b0, a}; we = 1'b0; ack = 1'b0;
        #1;
        check(name, dat_o, exp);
    endtask

    task automatic chk_out(input string name, input logic i_exp, input logic [2:0] v_exp);
        check({name, "_irq"}, irq, i_exp);
        check({name, "_vec"}, vec, v_exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mon_irq", irq, e.irq);
            check("mon_vec", vec, e.vec);
            check("mon_dat", dat_o, e.dat);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        bit r, w, k;
        bit [1:0] a;
        bit [31:0] d;

        rst_n = 1'b0; add = '0; we = 1'b0; dat_i = '0; ack = 1'b0; hwint = '0; hw_cur = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk_out("reset", 1'b0, 3'd0);
        peek(2'd0, "reset_mask", 32'h0);
        peek(2'd3, "reset_isr", 32'h0);

        // edge source 0
        wr(2'd0, 32'h8000_0001);
        wr(2'd2, 32'h0000_0001);
        hw_cur = 6'h01; step(1);
        chk_out("edge_lat1", 1'b0, 3'd0);
        hw_cur = 6'h00; step(1);
        chk_out("edge_req", 1'b1, 3'd0);
        ackc();
        chk_out("edge_ack", 1'b0, 3'd0);
        peek(2'd3, "edge_isr", 32'h8000_0200);
        peek(2'd1, "edge_pend", 32'h0);
        wr(2'd3, 32'h0);
        peek(2'd3, "edge_eoi", 32'h0);

        // level priority and preemption
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h8000_003F);
        hw_cur = 6'h10; step(2);
        chk_out("prio_req4", 1'b1, 3'd4);
        hw_cur = 6'h12; step(1);
        chk_out("prio_hold4", 1'b1, 3'd4);
        step(1);
        chk_out("prio_pre1", 1'b1, 3'd1);
        ackc();
        peek(2'd3, "prio_isr", 32'h8000_0201);
        hw_cur = 6'h10; step(1);
        wr(2'd3, 32'h0);
        step(1);
        chk_out("prio_rereq", 1'b1, 3'd4);
        ackc();
        hw_cur = 6'h00; step(1);
        wr(2'd3, 32'h0);

        // withdrawal by level drop, then by mask write
        wr(2'd0, 32'h8000_0004);
        hw_cur = 6'h04; step(2);
        chk_out("wd_req", 1'b1, 3'd2);
        hw_cur = 6'h00; step(1);
        check("wd_still", irq, 1'b1);
        step(1);
        check("wd_drop", irq, 1'b0);
        peek(2'd3, "wd_state", 32'h0);
        hw_cur = 6'h04; step(2);
        check("wdm_req", irq, 1'b1);
        wr(2'd0, 32'h8000_0000);
        check("wdm_still", irq, 1'b1);
        step(1);
        check("wdm_drop", irq, 1'b0);
        hw_cur = 6'h00; step(1);

        // global enable and W1C
        wr(2'd2, 32'h0000_0008);
        wr(2'd0, 32'h0000_0008);
        hw_cur = 6'h08; step(1);
        hw_cur = 6'h00; step(1);
        check("ge_off", irq, 1'b0);
        peek(2'd1, "ge_pend", 32'h08);
        hw_cur = 6'h08; cycle(hw_cur, 2'd1, 1'b1, 32'h08, 1'b0, 1'b1);
        peek(2'd1, "w1c_vs_edge", 32'h08);
        hw_cur = 6'h00; cycle(hw_cur, 2'd1, 1'b1, 32'h08, 1'b0, 1'b1);
        peek(2'd1, "w1c_clear", 32'h0);
        hw_cur = 6'h08; step(1);
        hw_cur = 6'h00; step(1);
        wr(2'd0, 32'h8000_0008);
        check("ge_on_lat", irq, 1'b0);
        step(1);
        chk_out("ge_req", 1'b1, 3'd3);
        ackc();
        peek(2'd1, "ge_ack_pend", 32'h0);
        peek(2'd3, "ge_isr", 32'h8000_0203);

        // service blocking
        wr(2'd2, 32'h0000_0029);
        wr(2'd0, 32'h8000_0029);
        hw_cur = 6'h21; step(1);
        hw_cur = 6'h00; ackc();
        check("serv_block", irq, 1'b0);
        peek(2'd1, "serv_pend", 32'h21);
        peek(2'd3, "serv_isr", 32'h8000_0203);
        wr(2'd3, 32'h0);
        step(1);
        chk_out("serv_next0", 1'b1, 3'd0);
        ackc();
        peek(2'd1, "serv_pend5", 32'h20);
        wr(2'd3, 32'h0);
        step(1);
        chk_out("serv_next5", 1'b1, 3'd5);
        ackc();
        wr(2'd3, 32'h0);

        // reset in service
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h8000_0002);
        hw_cur = 6'h02; step(2);
        chk_out("rst_req", 1'b1, 3'd1);
        ackc();
        cycle(hw_cur, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_out("rst_out", 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) peek(2'(i), "rst_regs", 32'h0);
        step(3);
        check("rst_nomask", irq, 1'b0);
        wr(2'd0, 32'h8000_0002);
        step(1);
        chk_out("rst_rereq", 1'b1, 3'd1);
        ackc();
        hw_cur = 6'h00;
        wr(2'd3, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, N - 1);
                hw_cur[idx] = ~hw_cur[idx];
            end
            w = ($urandom_range(0, 4) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd0 && $urandom_range(0, 3) != 0) d[31] = 1'b1;
            k = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cycle(hw_cur, a, w, d, k, r);
        end

        @(negedge clk);
        #1;
        check("queue_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
